// File: rtl/uart_cmd_master.sv
// uart_cmd_master
//   Host-side initiator for the 8-bit UART command protocol. Accepts one
//   command at a time (START, PM write, DM write, DM read) on a valid/ready
//   port, serializes its frame to a UART transmitter via tx_start/tx_done,
//   and for DM reads collects the two-byte reply from a UART receiver.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   cmd_valid  command request          cmd_ready  high only in IDLE
//   cmd_op     0=START 1=PM 2=DM wr 3=DM rd
//   cmd_addr   target address           cmd_data   write data
//   tx_start   one-cycle load pulse     d_out      byte to transmit
//   tx_done    UART tx finished a byte
//   rx_done    received-byte strobe     d_in       received byte
//   busy       not in IDLE              done       one-cycle completion pulse
//   rsp_data   DM read result           rsp_err    read-response timeout flag
//
// Build option
//   RESP_TIMEOUT_EN  when defined, a read whose reply stalls for
//                    TIMEOUT_CYCLES clocks finishes with rsp_err=1.
//                    When undefined, the receive states wait forever and
//                    rsp_err is tied low.

module uart_cmd_master #(
   parameter int SIZE           = 8,
   parameter int DATA_LENGTH    = 16,
   parameter int ADDR_LENGTH    = 11,
   parameter int HOLDOFF_CYCLES = 300,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [ADDR_LENGTH-1:0] cmd_addr,
   input  logic [DATA_LENGTH-1:0] cmd_data,
   output logic                   tx_start,
   output logic [SIZE-1:0]        d_out,
   input  logic                   tx_done,
   input  logic                   rx_done,
   input  logic [SIZE-1:0]        d_in,
   output logic                   busy,
   output logic                   done,
   output logic [DATA_LENGTH-1:0] rsp_data,
   output logic                   rsp_err
);

   typedef enum logic [2:0] {
      IDLE, LOAD, WAIT_TX, HOLDOFF, RX_LSB, RX_MSB, FINISH
   } state_t;

   typedef enum logic [1:0] {
      OP_START = 2'd0, OP_PM = 2'd1, OP_DM_WR = 2'd2, OP_DM_RD = 2'd3
   } op_t;

   // One counter serves both the post-START holdoff and the reply timeout.
   localparam int CNT_MAX = (HOLDOFF_CYCLES > TIMEOUT_CYCLES) ? HOLDOFF_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   state_t                 state, state_nxt;
   op_t                    op_q;
   logic [ADDR_LENGTH-1:0] addr_q;
   logic [DATA_LENGTH-1:0] data_q;
   logic [2:0]             idx, last_idx;
   logic [CNT_W-1:0]       cnt;
   logic                   lsb_got;
   logic                   accept, advance, cap_lsb, cap_msb, cnt_run;

`ifdef RESP_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic timeout;
`endif

   // Frame byte i of a command; address upper byte is zero-padded.
   function automatic logic [7:0] frame_byte(input op_t                    op,
                                             input logic [ADDR_LENGTH-1:0] addr,
                                             input logic [DATA_LENGTH-1:0] data,
                                             input logic [2:0]             i);
      logic [15:0] a16, d16;
      a16 = 16'(addr);
      d16 = 16'(data);
      case (i)
         3'd0:    frame_byte = 8'(op) + 8'h01;
         3'd1:    frame_byte = a16[7:0];
         3'd2:    frame_byte = a16[15:8];
         3'd3:    frame_byte = d16[7:0];
         default: frame_byte = d16[15:8];
      endcase
   endfunction

   always_comb begin
      case (op_q)
         OP_START: last_idx = 3'd0;
         OP_DM_RD: last_idx = 3'd2;
         default:  last_idx = 3'd4;
      endcase
   end

   // NOTE: every output of this block gets a default before the case so no
   // path leaves one unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      advance   = 1'b0;
      cap_lsb   = 1'b0;
      cap_msb   = 1'b0;
      cnt_run   = 1'b0;
`ifdef RESP_TIMEOUT_EN
      timeout   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: state_nxt = WAIT_TX;
         WAIT_TX: begin
            // A reply may overtake the final tx_done of a read frame.
            if (op_q == OP_DM_RD && idx == last_idx && rx_done && !lsb_got)
               cap_lsb = 1'b1;
            if (tx_done) begin
               if (idx != last_idx) begin
                  advance   = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  case (op_q)
                     OP_START: state_nxt = HOLDOFF;
                     OP_DM_RD: state_nxt = (lsb_got || cap_lsb) ? RX_MSB : RX_LSB;
                     default:  state_nxt = FINISH;
                  endcase
               end
            end
         end
         HOLDOFF: begin
            cnt_run = 1'b1;
            if (cnt == HOLD_LAST) state_nxt = FINISH;
         end
         RX_LSB: begin
            if (rx_done) begin
               cap_lsb   = 1'b1;
               state_nxt = RX_MSB;
            end
`ifdef RESP_TIMEOUT_EN
            else if (cnt == TO_LAST) begin
               timeout   = 1'b1;
               state_nxt = FINISH;
            end else begin
               cnt_run = 1'b1;
            end
`endif
         end
         RX_MSB: begin
            if (rx_done) begin
               cap_msb   = 1'b1;
               state_nxt = FINISH;
            end
`ifdef RESP_TIMEOUT_EN
            else if (cnt == TO_LAST) begin
               timeout   = 1'b1;
               state_nxt = FINISH;
            end else begin
               cnt_run = 1'b1;
            end
`endif
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         op_q     <= OP_START;
         addr_q   <= '0;
         data_q   <= '0;
         idx      <= '0;
         cnt      <= '0;
         lsb_got  <= 1'b0;
         d_out    <= '0;
         rsp_data <= '0;
      end else begin
         state <= state_nxt;
         // Counter restarts on every state change (entry, and rx_done in RX).
         if (state_nxt != state) cnt <= '0;
         else if (cnt_run)       cnt <= cnt + CNT_W'(1);
         if (accept) begin
            op_q    <= op_t'(cmd_op);
            addr_q  <= cmd_addr;
            data_q  <= cmd_data;
            idx     <= 3'd0;
            lsb_got <= 1'b0;
            d_out   <= SIZE'(frame_byte(op_t'(cmd_op), cmd_addr, cmd_data, 3'd0));
         end
         if (advance) begin
            idx   <= idx + 3'd1;
            d_out <= SIZE'(frame_byte(op_q, addr_q, data_q, idx + 3'd1));
         end
         if (cap_lsb) begin
            rsp_data[7:0] <= d_in[7:0];
            lsb_got       <= 1'b1;
         end
         if (cap_msb) rsp_data[15:8] <= d_in[7:0];
      end
   end

`ifdef RESP_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       rsp_err <= 1'b0;
      else if (accept)  rsp_err <= 1'b0;
      else if (timeout) rsp_err <= 1'b1;
   end
`else
   assign rsp_err = 1'b0;
`endif

   assign tx_start  = (state == LOAD);
   assign done      = (state == FINISH);
   assign busy      = (state != IDLE);
   assign cmd_ready = (state == IDLE);

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master
//   Self-checking bench for uart_cmd_master. A UART model answers every
//   tx_start with a tx_done pulse TX_LAT clocks later and compares each
//   transmitted byte against a queue of expected frame bytes. Commands come
//   from a vector table; holdoff, timeout and mid-frame reset are separate
//   sequences.

module tb_uart_cmd_master;
   localparam int SIZE        = 8;
   localparam int DATA_LENGTH = 16;
   localparam int ADDR_LENGTH = 11;
   localparam int HOLDOFF     = 300;
   localparam int TIMEOUT     = 50;
   localparam int TX_LAT      = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   cmd_valid, cmd_ready;
   logic [1:0]             cmd_op;
   logic [ADDR_LENGTH-1:0] cmd_addr;
   logic [DATA_LENGTH-1:0] cmd_data;
   logic                   tx_start, tx_done, rx_done;
   logic [SIZE-1:0]        d_out, d_in;
   logic                   busy, done, rsp_err;
   logic [DATA_LENGTH-1:0] rsp_data;

   uart_cmd_master #(
      .SIZE(SIZE), .DATA_LENGTH(DATA_LENGTH), .ADDR_LENGTH(ADDR_LENGTH),
      .HOLDOFF_CYCLES(HOLDOFF), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .tx_start(tx_start), .d_out(d_out), .tx_done(tx_done),
      .rx_done(rx_done), .d_in(d_in), .busy(busy), .done(done),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [10:0] addr;
      logic [15:0] data;
      logic [7:0]  rx0;
      logic [7:0]  rx1;
      int          mode;     // read: 0 reply after frame, 1 LSB early, 2 LSB with last tx_done
      logic [15:0] exp_rsp;  // write/START: mode 1 injects a stray 8'hAA
   } vec_t;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   int         tx_wait  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int frame_len(input logic [1:0] op);
      return (op == 2'd0) ? 1 : (op == 2'd3) ? 3 : 5;
   endfunction

   function automatic void push_frame(input logic [1:0] op, input logic [10:0] addr,
                                      input logic [15:0] data);
      exp_q.push_back(8'(op) + 8'h01);
      if (op != 2'd0) begin
         exp_q.push_back(addr[7:0]);
         exp_q.push_back({5'b0, addr[10:8]});
         if (op != 2'd3) begin
            exp_q.push_back(data[7:0]);
            exp_q.push_back(data[15:8]);
         end
      end
   endfunction

   // UART transmitter model and byte scoreboard, evaluated on every negedge.
   initial begin : uart_model
      logic       pending;
      logic [7:0] last_byte;
      last_byte = 8'h00;
      tx_done   = 1'b0;
      forever begin
         @(negedge clk);
         pending = (tx_wait != 0);
         tx_done = 1'b0;
         if (tx_wait != 0) begin
            tx_wait = tx_wait - 1;
            if (tx_wait == 0) begin
               tx_done = 1'b1;
               if (busy) check("d_out_held", d_out, last_byte);
            end
         end
         if (tx_start) begin
            check("tx_start_while_busy", pending, 1'b0);
            check("tx_byte_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("d_out", d_out, exp_q.pop_front());
            last_byte = d_out;
            tx_wait   = TX_LAT;
         end
      end
   end

   initial begin : watchdog
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic rx_pulse(input logic [7:0] b);
      @(negedge clk);
      rx_done = 1'b1;
      d_in    = b;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   // Leaves the caller at the negedge where the first tx_start is visible.
   task automatic issue(input logic [1:0] op, input logic [10:0] addr, input logic [15:0] data);
      @(negedge clk);
      check("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("accept_to_tx_start", tx_start, 1'b1);
      check("busy_after_accept", busy, 1'b1);
      check("rsp_err_clear_on_accept", rsp_err, 1'b0);
   endtask

   // Returns at the negedge where the last tx_start of the frame is visible.
   task automatic wait_frame(input int nb);
      int seen  = 1;
      int guard = 0;
      while (seen < nb && guard < 100) begin
         @(negedge clk);
         guard++;
         if (tx_start) seen++;
      end
      check("frame_length", seen, nb);
   endtask

   task automatic wait_done(output int k);
      k = 0;
      while (!done && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", done, 1'b1);
   endtask

   task automatic finish_cmd(input logic [15:0] exp_rsp);
      int k;
      wait_done(k);
      check("rsp_data", rsp_data, exp_rsp);
      check("rsp_err_clear", rsp_err, 1'b0);
      check("frame_bytes_all_sent", exp_q.size(), 0);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("ready_after_done", cmd_ready, 1'b1);
   endtask

   task automatic run_vec(input vec_t v);
      push_frame(v.op, v.addr, v.data);
      issue(v.op, v.addr, v.data);
      wait_frame(frame_len(v.op));
      if (v.op == 2'd3) begin
         case (v.mode)
            1: begin
               rx_pulse(v.rx0);              // lands in WAIT_TX of the last byte
               repeat (2) @(negedge clk);
               rx_pulse(v.rx1);
            end
            2: begin
               @(negedge clk);
               rx_pulse(v.rx0);              // same cycle as the last tx_done
               rx_pulse(v.rx1);
            end
            default: begin
               repeat (3) @(negedge clk);
               rx_pulse(v.rx0);
               rx_pulse(v.rx1);
            end
         endcase
      end else if (v.mode == 1) begin
         rx_pulse(8'hAA);
      end
      finish_cmd(v.exp_rsp);
   endtask

   initial begin : main
      vec_t vecs[9];
      int   k, low;
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
      rx_done = 1'b0; d_in = '0;

      #3;
      check("reset_cmd_ready", cmd_ready, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_tx_start", tx_start, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_d_out", d_out, 8'h00);
      check("reset_rsp_data", rsp_data, 16'h0000);
      check("reset_rsp_err", rsp_err, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      vecs[0] = '{2'd1, 11'h123, 16'hBEEF, 8'h00, 8'h00, 0, 16'h0000};
      vecs[1] = '{2'd3, 11'h7FF, 16'h0000, 8'h34, 8'h12, 0, 16'h1234};
      vecs[2] = '{2'd3, 11'h000, 16'h0000, 8'h00, 8'hFF, 2, 16'hFF00};
      vecs[3] = '{2'd3, 11'h7FF, 16'h0000, 8'h34, 8'h12, 1, 16'h1234};
      vecs[4] = '{2'd2, 11'h0A5, 16'h5A5A, 8'h00, 8'h00, 1, 16'h1234};
      vecs[5] = '{2'd0, 11'h000, 16'h0000, 8'h00, 8'h00, 0, 16'h1234};
      vecs[6] = '{2'd3, 11'h100, 16'h0000, 8'hCD, 8'hAB, 0, 16'hABCD};
      vecs[7] = '{2'd1, 11'h000, 16'h0000, 8'h00, 8'h00, 1, 16'hABCD};
      vecs[8] = '{2'd2, 11'h7FF, 16'hFFFF, 8'h00, 8'h00, 0, 16'hABCD};
      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Stray receive byte while idle.
      rx_pulse(8'hAA);
      repeat (2) @(negedge clk);
      check("idle_stray_rsp_data", rsp_data, 16'hABCD);
      check("idle_stray_busy", busy, 1'b0);

      // START holdoff with cmd_valid held high throughout.
      push_frame(2'd0, 11'h000, 16'h0000);
      @(negedge clk);
      check("start_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_op = 2'd0;
      @(negedge clk);
      check("start_tx_start", tx_start, 1'b1);
      cmd_op = 2'd1; cmd_addr = 11'h321; cmd_data = 16'hA55A;
      k = 0; low = 0;
      while (!done && k < 2000) begin
         @(negedge clk);
         k++;
         if (!cmd_ready) low++;
      end
      check("holdoff_done_latency", k, TX_LAT + 1 + HOLDOFF);
      check("holdoff_ready_low", low, k);
      push_frame(2'd1, 11'h321, 16'hA55A);
      @(negedge clk);
      check("post_holdoff_ready", cmd_ready, 1'b1);
      @(negedge clk);
      check("post_holdoff_accept", tx_start, 1'b1);
      cmd_valid = 1'b0;
      wait_frame(5);
      finish_cmd(16'hABCD);

`ifdef RESP_TIMEOUT_EN
      // DM read with no reply.
      push_frame(2'd3, 11'h2AA, 16'h0000);
      issue(2'd3, 11'h2AA, 16'h0000);
      wait_frame(3);
      wait_done(k);
      check("timeout_latency", k, TX_LAT + 1 + TIMEOUT);
      check("timeout_rsp_err", rsp_err, 1'b1);
      check("timeout_rsp_data", rsp_data, 16'hABCD);
      @(negedge clk);
      check("timeout_done_one_cycle", done, 1'b0);
      run_vec('{2'd2, 11'h011, 16'h2222, 8'h00, 8'h00, 0, 16'hABCD});
`endif

      // Reset in the middle of a DM write frame.
      push_frame(2'd2, 11'h055, 16'h1357);
      issue(2'd2, 11'h055, 16'h1357);
      wait_frame(2);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("midreset_tx_start", tx_start, 1'b0);
      check("midreset_busy", busy, 1'b0);
      check("midreset_cmd_ready", cmd_ready, 1'b1);
      check("midreset_done", done, 1'b0);
      check("midreset_rsp_data", rsp_data, 16'h0000);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      run_vec('{2'd2, 11'h1C3, 16'h8001, 8'h00, 8'h00, 0, 16'h0000});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
